// File: rtl/fads_pkg.sv
// rtl/fads_pkg.sv - shared FADS sort-pulser state encoding, register map and config defaults
package fads_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_BURST   = 2'd2,
        ST_HOLDOFF = 2'd3
    } sort_state_t;

    localparam logic [19:0] REG_CTRL     = 20'h00200;
    localparam logic [19:0] REG_DELAY    = 20'h00204;
    localparam logic [19:0] REG_HALF_PER = 20'h00208;
    localparam logic [19:0] REG_N_CYC    = 20'h0020C;
    localparam logic [19:0] REG_AMP      = 20'h00210;
    localparam logic [19:0] REG_HOLDOFF  = 20'h00214;
    localparam logic [19:0] REG_STATUS   = 20'h00220;
    localparam logic [19:0] REG_ACCEPTED = 20'h00224;
    localparam logic [19:0] REG_DROPPED  = 20'h00228;

    localparam int unsigned DEF_DELAY    = 0;
    localparam int unsigned DEF_HALF_PER = 62;
    localparam int unsigned DEF_N_CYC    = 10;
    localparam int unsigned DEF_AMP      = 4096;
    localparam int unsigned DEF_HOLDOFF  = 1250;

endpackage

// File: rtl/red_pitaya_sort_regs.sv
// rtl/red_pitaya_sort_regs.sv - bus decode, live/shadow config, event counters and readback
module red_pitaya_sort_regs
    import fads_pkg::*;
#(
    parameter int DWD = 14,
    parameter int CW  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [19:0]           addr,
    input  logic [31:0]           wdata,
    input  logic                  wen,
    input  logic                  ren,
    output logic [31:0]           rdata,
    output logic                  ack,
    input  sort_state_t           state,
    input  logic                  accept,
    input  logic                  drop,
    output logic                  enable,
    output logic                  sw_trig,
    output logic                  abort,
    output logic [CW-1:0]         sh_delay,
    output logic [CW-1:0]         sh_half_per,
    output logic [CW-1:0]         sh_n_cyc,
    output logic [CW-1:0]         sh_holdoff,
    output logic signed [DWD-1:0] sh_amp
);

    localparam logic [DWD-1:0] AMP_MIN = {1'b1, {(DWD-1){1'b0}}};
    localparam logic [DWD-1:0] AMP_MAX = {1'b0, {(DWD-1){1'b1}}};

    logic [CW-1:0]  cfg_delay, cfg_half_per, cfg_n_cyc, cfg_holdoff;
    logic [DWD-1:0] cfg_amp;
    logic [CW-1:0]  accepted, dropped;
    logic [31:0]    rd_mux;
    logic           unused_wdata;

    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable       <= 1'b0;
            sw_trig      <= 1'b0;
            abort        <= 1'b0;
            cfg_delay    <= CW'(DEF_DELAY);
            cfg_half_per <= CW'(DEF_HALF_PER);
            cfg_n_cyc    <= CW'(DEF_N_CYC);
            cfg_amp      <= DWD'(DEF_AMP);
            cfg_holdoff  <= CW'(DEF_HOLDOFF);
        end else begin
            sw_trig <= 1'b0;
            abort   <= 1'b0;
            if (wen) begin
                case (addr)
                    REG_CTRL: begin
                        enable  <= wdata[0];
                        sw_trig <= wdata[1];
                        abort   <= wdata[2];
                    end
                    REG_DELAY:    cfg_delay    <= wdata[CW-1:0];
                    REG_HALF_PER: cfg_half_per <= wdata[CW-1:0];
                    REG_N_CYC:    cfg_n_cyc    <= wdata[CW-1:0];
                    REG_AMP:      cfg_amp      <= wdata[DWD-1:0];
                    REG_HOLDOFF:  cfg_holdoff  <= wdata[CW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Shadow copy taken at accept so bus writes never disturb a running burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_delay    <= CW'(DEF_DELAY);
            sh_half_per <= CW'(DEF_HALF_PER);
            sh_n_cyc    <= CW'(DEF_N_CYC);
            sh_holdoff  <= CW'(DEF_HOLDOFF);
            sh_amp      <= DWD'(DEF_AMP);
        end else if (accept) begin
            sh_delay    <= cfg_delay;
            sh_half_per <= (cfg_half_per == '0) ? CW'(1) : cfg_half_per;
            sh_n_cyc    <= cfg_n_cyc;
            sh_holdoff  <= cfg_holdoff;
            sh_amp      <= (cfg_amp == AMP_MIN) ? AMP_MAX : cfg_amp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted <= '0;
            dropped  <= '0;
        end else begin
            if (accept) accepted <= accepted + CW'(1);
            if (drop)   dropped  <= dropped + CW'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_CTRL:     rd_mux = {31'b0, enable};
            REG_DELAY:    rd_mux = 32'(cfg_delay);
            REG_HALF_PER: rd_mux = 32'(cfg_half_per);
            REG_N_CYC:    rd_mux = 32'(cfg_n_cyc);
            REG_AMP:      rd_mux = 32'(cfg_amp);
            REG_HOLDOFF:  rd_mux = 32'(cfg_holdoff);
            REG_STATUS:   rd_mux = {30'b0, state};
            REG_ACCEPTED: rd_mux = 32'(accepted);
            REG_DROPPED:  rd_mux = 32'(dropped);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= wen | ren;
            rdata <= ren ? rd_mux : '0;
        end
    end

endmodule

// File: rtl/red_pitaya_sort_pulser.sv
// rtl/red_pitaya_sort_pulser.sv - sort trigger to delayed bipolar DAC burst with holdoff
module red_pitaya_sort_pulser
    import fads_pkg::*;
#(
    parameter int DWD = 14,
    parameter int CW  = 32
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rstn_i,
    input  logic                  sort_trig_i,
    output logic signed [DWD-1:0] dac_o,
    output logic                  busy_o,
    input  logic [31:0]           sys_addr,
    input  logic [31:0]           sys_wdata,
    input  logic [3:0]            sys_sel,
    input  logic                  sys_wen,
    input  logic                  sys_ren,
    output logic [31:0]           sys_rdata,
    output logic                  sys_err,
    output logic                  sys_ack
);

    sort_state_t           state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx, cyc, cyc_nx;
    logic                  pol, pol_nx;
    logic signed [DWD-1:0] dac_nx;
    logic                  trig_q, trig_rise, req, accept, drop, stop;
    logic                  enable, sw_trig, abort;
    logic [CW-1:0]         sh_delay, sh_half_per, sh_n_cyc, sh_holdoff;
    logic signed [DWD-1:0] sh_amp;
    logic                  unused_bus;

    assign unused_bus = ^{sys_sel, sys_addr[31:20]};
    assign sys_err    = 1'b0;
    assign busy_o     = (state != ST_IDLE);

    assign trig_rise = sort_trig_i & ~trig_q;
    assign req       = trig_rise | sw_trig;
    assign accept    = req & enable & (state == ST_IDLE);
    assign drop      = req & ~accept;
    assign stop      = (state != ST_IDLE) & (abort | ~enable);

    red_pitaya_sort_regs #(.DWD(DWD), .CW(CW)) u_regs (
        .clk         (adc_clk_i),
        .rst_n       (adc_rstn_i),
        .addr        (sys_addr[19:0]),
        .wdata       (sys_wdata),
        .wen         (sys_wen),
        .ren         (sys_ren),
        .rdata       (sys_rdata),
        .ack         (sys_ack),
        .state       (state),
        .accept      (accept),
        .drop        (drop),
        .enable      (enable),
        .sw_trig     (sw_trig),
        .abort       (abort),
        .sh_delay    (sh_delay),
        .sh_half_per (sh_half_per),
        .sh_n_cyc    (sh_n_cyc),
        .sh_holdoff  (sh_holdoff),
        .sh_amp      (sh_amp)
    );

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cyc    <= '0;
            pol    <= 1'b0;
            dac_o  <= '0;
            trig_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            cyc    <= cyc_nx;
            pol    <= pol_nx;
            dac_o  <= dac_nx;
            trig_q <= sort_trig_i;
        end
    end

    // cnt times DELAY (delay+1 clocks), each half period in BURST, and HOLDOFF.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cyc_nx   = cyc;
        pol_nx   = pol;
        dac_nx   = dac_o;
        if (stop) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            dac_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_nx = ST_DELAY;
                        cnt_nx   = '0;
                    end
                end
                ST_DELAY: begin
                    if (cnt == sh_delay) begin
                        cnt_nx = '0;
                        cyc_nx = '0;
                        pol_nx = 1'b0;
                        if (sh_n_cyc == '0) begin
                            state_nx = ST_HOLDOFF;
                            dac_nx   = '0;
                        end else begin
                            state_nx = ST_BURST;
                            dac_nx   = sh_amp;
                        end
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                ST_BURST: begin
                    if (cnt == sh_half_per - CW'(1)) begin
                        cnt_nx = '0;
                        if (!pol) begin
                            pol_nx = 1'b1;
                            dac_nx = -sh_amp;
                        end else if (cyc == sh_n_cyc - CW'(1)) begin
                            state_nx = ST_HOLDOFF;
                            dac_nx   = '0;
                        end else begin
                            cyc_nx = cyc + CW'(1);
                            pol_nx = 1'b0;
                            dac_nx = sh_amp;
                        end
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (sh_holdoff == '0 || cnt == sh_holdoff - CW'(1)) begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_red_pitaya_sort_pulser.sv
// tb/tb_red_pitaya_sort_pulser.sv - randomized scenario bench with a waveform-level reference model
module tb_red_pitaya_sort_pulser;
    import fads_pkg::*;

    localparam int DWD  = 14;
    localparam int CW   = 12;
    localparam int WRAP = 1 << CW;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  trig  = 1'b0;
    logic signed [DWD-1:0] dac;
    logic                  busy;
    logic [31:0]           addr  = '0;
    logic [31:0]           wdata = '0;
    logic [3:0]            sel   = 4'hf;
    logic                  wen   = 1'b0;
    logic                  ren   = 1'b0;
    logic [31:0]           rdata;
    logic                  err;
    logic                  ack;

    int errors = 0;
    int checks = 0;
    int m_acc  = 0;
    int m_drop = 0;
    int c_delay = 0, c_hp = 62, c_n = 10, c_amp = 4096, c_hold = 1250;

    always #4 clk = ~clk;

    red_pitaya_sort_pulser #(.DWD(DWD), .CW(CW)) dut (
        .adc_clk_i   (clk),
        .adc_rstn_i  (rst_n),
        .sort_trig_i (trig),
        .dac_o       (dac),
        .busy_o      (busy),
        .sys_addr    (addr),
        .sys_wdata   (wdata),
        .sys_sel     (sel),
        .sys_wen     (wen),
        .sys_ren     (ren),
        .sys_rdata   (rdata),
        .sys_err     (err),
        .sys_ack     (ack)
    );

    task automatic bus_write(input logic [19:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        addr = {12'h400, a}; wdata = d; wen = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [19:0] a, output logic [31:0] d, output logic k);
        @(posedge clk); #1;
        addr = {12'h400, a}; ren = 1'b1;
        @(posedge clk); #1;
        ren = 1'b0; d = rdata; k = ack;
    endtask

    task automatic set_cfg(input int d, input int hp, input int n, input int amp, input int hold);
        bus_write(REG_DELAY, d);    c_delay = d;
        bus_write(REG_HALF_PER, hp); c_hp = hp;
        bus_write(REG_N_CYC, n);    c_n = n;
        bus_write(REG_AMP, amp);    c_amp = amp;
        bus_write(REG_HOLDOFF, hold); c_hold = hold;
    endtask

    function automatic int amp_pos();
        int a = c_amp & 32'h3fff;
        if (a == 32'h2000) a = 32'h1fff;
        return (a >= 8192) ? a - 16384 : a;
    endfunction

    function automatic int exp_dac(int idx, int lead, int hpe, int b_len, int pos);
        if (idx < lead || idx >= lead + b_len) return 0;
        return (((idx - lead) / hpe) % 2 == 0) ? pos : -pos;
    endfunction

    task automatic run_shot(input string name, input bit use_sw, input int second_at,
                            input int wr_at, input logic [19:0] wr_addr, input logic [31:0] wr_val);
        int acc_j = use_sw ? 2 : 1;
        int lead  = acc_j + c_delay;
        int hpe   = (c_hp == 0) ? 1 : c_hp;
        int b_len = 2 * hpe * c_n;
        int hold  = (c_hold == 0) ? 1 : c_hold;
        int end_j = lead + 1 + b_len + hold;
        int pos   = amp_pos();
        int e;
        logic [31:0] d;
        logic k;
        @(posedge clk); #1;
        if (use_sw) begin addr = {12'h0, REG_CTRL}; wdata = 32'h3; wen = 1'b1; end
        else trig = 1'b1;
        for (int j = 1; j <= end_j; j++) begin
            @(posedge clk); #1;
            trig = (j == second_at);
            wen  = (j == wr_at);
            if (j == wr_at) begin addr = {12'h0, wr_addr}; wdata = wr_val; end
            @(negedge clk);
            e = exp_dac(j - 1, lead, hpe, b_len, pos);
            checks++;
            if (int'(dac) !== e) begin
                errors++;
                $display("FAIL %s dac[%0d]: got %0d expected %0d", name, j, dac, e);
            end
            checks++;
            if (busy !== logic'(j >= acc_j && j < end_j)) begin
                errors++;
                $display("FAIL %s busy[%0d]: got %b expected %b", name, j, busy, (j >= acc_j && j < end_j));
            end
        end
        m_acc = (m_acc + 1) % WRAP;
        if (second_at > 0) m_drop++;
        bus_read(REG_ACCEPTED, d, k);
        checks++;
        if (d !== 32'(m_acc)) begin errors++; $display("FAIL %s accepted: got %0d expected %0d", name, d, m_acc); end
        bus_read(REG_DROPPED, d, k);
        checks++;
        if (d !== 32'(m_drop)) begin errors++; $display("FAIL %s dropped: got %0d expected %0d", name, d, m_drop); end
    endtask

    task automatic test_register_defaults(input string name);
        logic [19:0] a_tab [10] = '{REG_CTRL, REG_DELAY, REG_HALF_PER, REG_N_CYC, REG_AMP,
                                    REG_HOLDOFF, REG_STATUS, REG_ACCEPTED, REG_DROPPED, 20'h00300};
        int v_tab [10] = '{0, 0, 62, 10, 4096, 1250, 0, 0, 0, 0};
        logic [31:0] d;
        logic k;
        for (int i = 0; i < 10; i++) begin
            bus_read(a_tab[i], d, k);
            checks++;
            if (d !== 32'(v_tab[i]) || k !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s reg 0x%0h: got %0d ack=%b err=%b expected %0d ack=1 err=0", name, a_tab[i], d, k, err, v_tab[i]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dac !== '0 || busy !== 1'b0 || ack !== 1'b0 || rdata !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: dac=%0d busy=%b ack=%b rdata=%0d err=%b expected all 0", dac, busy, ack, rdata, err);
        end
        rst_n = 1'b1;
        test_register_defaults("reset");
    endtask

    task automatic test_basic();
        bus_write(REG_CTRL, 32'h1);
        set_cfg(0, 2, 2, 100, 0);
        run_shot("basic", 1'b0, 0, 0, 20'h0, 32'h0);
    endtask

    task automatic test_drop_while_busy();
        set_cfg(5, 2, 2, 100, 10);
        run_shot("drop_busy", 1'b0, 1 + 5 + 3, 0, 20'h0, 32'h0);
        run_shot("after_holdoff", 1'b0, 0, 0, 20'h0, 32'h0);
    endtask

    task automatic test_disabled();
        logic [31:0] d;
        logic k;
        bus_write(REG_CTRL, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 trig = 1'b1;
            @(posedge clk); #1 trig = 1'b0;
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (dac !== '0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL disabled: dac=%0d busy=%b expected 0/0", dac, busy);
                end
            end
        end
        m_drop += 3;
        bus_read(REG_ACCEPTED, d, k);
        checks++;
        if (d !== 32'(m_acc)) begin errors++; $display("FAIL disabled accepted: got %0d expected %0d", d, m_acc); end
        bus_read(REG_DROPPED, d, k);
        checks++;
        if (d !== 32'(m_drop)) begin errors++; $display("FAIL disabled dropped: got %0d expected %0d", d, m_drop); end
        bus_write(REG_CTRL, 32'h1);
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic k;
        set_cfg(1, 4, 4, 100, 2);
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
        repeat (5) @(posedge clk);
        bus_write(REG_CTRL, 32'h5);
        @(negedge clk);
        checks++;
        if (dac === '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort pre-edge: dac=%0d busy=%b expected nonzero/1", dac, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (dac !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort edge: dac=%0d busy=%b expected 0/0", dac, busy);
        end
        m_acc = (m_acc + 1) % WRAP;
        bus_read(REG_STATUS, d, k);
        checks++;
        if (d !== 32'(0)) begin errors++; $display("FAIL abort status: got %0d expected 0", d); end
        bus_read(REG_ACCEPTED, d, k);
        checks++;
        if (d !== 32'(m_acc)) begin errors++; $display("FAIL abort accepted: got %0d expected %0d", d, m_acc); end
    endtask

    task automatic test_amp_shadow();
        set_cfg(1, 4, 2, 100, 2);
        run_shot("amp_during_burst", 1'b0, 0, 5, REG_AMP, 32'd50);
        c_amp = 50;
        run_shot("amp_next_burst", 1'b0, 0, 0, 20'h0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(1, 8191), $urandom_range(0, 5));
            run_shot("random", i[0], 0, 0, 20'h0, 32'h0);
        end
    endtask

    task automatic test_corners();
        set_cfg(0, 0, 1, 300, 0);
        run_shot("half_per_zero", 1'b0, 0, 0, 20'h0, 32'h0);
        set_cfg(2, 3, 0, 300, 1);
        run_shot("n_cyc_zero", 1'b0, 0, 0, 20'h0, 32'h0);
        set_cfg(0, 1, 2, 32'h2000, 0);
        run_shot("amp_saturate", 1'b0, 0, 0, 20'h0, 32'h0);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic k;
        set_cfg(0, 1, 0, 1, 0);
        while (m_acc != WRAP - 1) begin
            @(posedge clk); #1 trig = 1'b1;
            @(posedge clk); #1 trig = 1'b0;
            repeat (2) @(posedge clk);
            m_acc++;
        end
        bus_read(REG_ACCEPTED, d, k);
        checks++;
        if (d !== 32'(WRAP - 1)) begin errors++; $display("FAIL wrap max: got %0d expected %0d", d, WRAP - 1); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 trig = 1'b1;
            @(posedge clk); #1 trig = 1'b0;
            repeat (2) @(posedge clk);
            m_acc = (m_acc + 1) % WRAP;
            bus_read(REG_ACCEPTED, d, k);
            checks++;
            if (d !== 32'(i)) begin errors++; $display("FAIL wrap step %0d: got %0d expected %0d", i, d, i); end
        end
        bus_read(REG_DROPPED, d, k);
        checks++;
        if (d !== 32'(m_drop)) begin errors++; $display("FAIL wrap dropped: got %0d expected %0d", d, m_drop); end
    endtask

    task automatic test_async_reset();
        set_cfg(0, 4, 4, 100, 3);
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (dac === '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async pre-reset: dac=%0d busy=%b expected nonzero/1", dac, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dac !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async reset: dac=%0d busy=%b expected 0/0", dac, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        m_acc = 0; m_drop = 0;
        test_register_defaults("async_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop_while_busy();
        test_disabled();
        test_abort();
        test_amp_shadow();
        test_random();
        test_corners();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
